// File: rtl/drc_pkg.sv
// Shared encodings for the DVP RX controller: capture state machine states,
// CSR RX mode field, scheduler modes and interrupt status bit positions.
package drc_pkg;

  typedef enum logic [2:0] {
    CS_SLEEP   = 3'd0,
    CS_IDLE    = 3'd1,
    CS_ALIGN   = 3'd2,
    CS_CAPTURE = 3'd3,
    CS_ERRCOR  = 3'd4
  } cs_state_e;

  typedef enum logic [1:0] {
    RXM_SLEEP  = 2'd0,
    RXM_SINGLE = 2'd1,
    RXM_STREAM = 2'd2,
    RXM_RSVD   = 2'd3
  } rx_mode_e;

  typedef enum logic [1:0] {
    SCH_OFF = 2'd0,
    SCH_SNG = 2'd1,
    SCH_STR = 2'd2
  } sched_mode_e;

  localparam int STS_W    = 4;
  localparam int STS_COMP = 0;
  localparam int STS_ERR  = 1;
  localparam int STS_OVF  = 2;
  localparam int STS_WDT  = 3;

  // States in which a frame is in flight and may get stuck.
  function automatic logic cs_in_frame(input logic [2:0] state);
    return (state == CS_ALIGN) || (state == CS_CAPTURE) || (state == CS_ERRCOR);
  endfunction

endpackage

// File: rtl/drc_sched_wdt.sv
// Frame watchdog: counts cycles spent in one in-frame state of the capture
// state machine and emits a single-cycle hit when the count reaches the limit.
// A limit of zero disables it. Only instantiated when DRC_SCHED_WDT_EN is set.
module drc_sched_wdt
  import drc_pkg::*;
#(
  parameter int WDT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       i_state,
  input  logic [WDT_W-1:0] i_limit,
  output logic             o_hit
);

  logic [2:0]       r_state_q;
  logic [WDT_W-1:0] r_cnt;
  logic [WDT_W-1:0] w_cnt_nxt;
  logic             w_active;
  logic             w_chg;
  logic             w_adv;

  // r_cnt is the number of cycles already spent in the current state; the
  // first cycle after a state change loads 1 so the hit lands exactly
  // i_limit cycles after entry. Once at the limit the count holds.
  always_comb begin
    w_active  = cs_in_frame(i_state) && (i_limit != '0);
    w_chg     = (i_state != r_state_q);
    w_adv     = w_active && (w_chg || (r_cnt < i_limit));
    w_cnt_nxt = r_cnt;
    if (!w_active) begin
      w_cnt_nxt = '0;
    end else if (w_chg) begin
      w_cnt_nxt = WDT_W'(1);
    end else if (r_cnt < i_limit) begin
      w_cnt_nxt = r_cnt + WDT_W'(1);
    end
    o_hit = w_adv && (w_cnt_nxt == i_limit);
  end

  // Count register and last-seen state for change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_state_q <= CS_SLEEP;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_state_q <= i_state;
    end
  end

endmodule

// File: rtl/drc_start_scheduler.sv
// Start-request scheduler and interrupt aggregator for the DVP RX controller.
// Queues software starts toward the capture state machine, turns its
// frame-complete/error pulses into sticky W1C status with a masked irq, and
// keeps saturating frame/error counters.
// Optional frame watchdog: define DRC_SCHED_WDT_EN to build it; otherwise
// irq_sts[3] is constant 0 and wdt_limit is ignored.
module drc_start_scheduler
  import drc_pkg::*;
#(
  parameter int START_Q_DEPTH = 4,
  parameter int START_Q_W     = $clog2(START_Q_DEPTH + 1),
  parameter int CNT_W         = 16,
  parameter int WDT_W         = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cam_rx_en,
  input  logic [1:0]           cam_rx_mode,
  input  logic                 sw_start,
  input  logic                 sw_stop,
  output logic                 cam_rx_start,
  input  logic                 cam_rx_start_qed,
  input  logic [2:0]           cam_rx_state,
  input  logic                 frm_comp_pls,
  input  logic                 frm_err_pls,
  input  logic [3:0]           irq_en,
  input  logic [3:0]           irq_clr,
  input  logic                 cnt_clr,
  input  logic [WDT_W-1:0]     wdt_limit,
  output logic [3:0]           irq_sts,
  output logic                 irq,
  output logic [START_Q_W-1:0] start_pend,
  output logic [1:0]           sched_mode,
  output logic [CNT_W-1:0]     frm_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam logic [START_Q_W-1:0] PEND_FULL = START_Q_W'(START_Q_DEPTH);

  sched_mode_e          r_mode;
  sched_mode_e          w_mode_nxt;
  logic [START_Q_W-1:0] r_pend;
  logic [START_Q_W-1:0] w_pend_nxt;
  logic                 r_armed;
  logic                 w_armed_nxt;
  logic                 w_ovf;
  logic                 w_pop_ok;
  logic                 w_wdt_hit;
  logic [STS_W-1:0]     r_sts;
  logic [STS_W-1:0]     w_sts_set;
  logic [CNT_W-1:0]     r_frm;
  logic [CNT_W-1:0]     r_err;

`ifdef DRC_SCHED_WDT_EN
  drc_sched_wdt #(
    .WDT_W (WDT_W)
  ) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .i_state (cam_rx_state),
    .i_limit (wdt_limit),
    .o_hit   (w_wdt_hit)
  );
`else
  logic w_unused_wdt;
  assign w_unused_wdt = ^{cam_rx_state, wdt_limit};
  assign w_wdt_hit    = 1'b0;
`endif

  // Mode state register plus pending count and stream-armed flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= SCH_OFF;
      r_pend  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_pend  <= w_pend_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  // Next mode from CSR fields; start queue / armed flag update for the
  // current mode. A mode change discards everything queued or armed.
  always_comb begin
    w_mode_nxt  = SCH_OFF;
    w_pend_nxt  = r_pend;
    w_armed_nxt = r_armed;
    w_ovf       = 1'b0;
    w_pop_ok    = cam_rx_start_qed && (r_pend != '0);

    if (cam_rx_en) begin
      case (cam_rx_mode)
        RXM_SINGLE: w_mode_nxt = SCH_SNG;
        RXM_STREAM: w_mode_nxt = SCH_STR;
        default:    w_mode_nxt = SCH_OFF;
      endcase
    end

    if (w_mode_nxt != r_mode) begin
      w_pend_nxt  = '0;
      w_armed_nxt = 1'b0;
    end else begin
      case (r_mode)
        SCH_SNG: begin
          if (sw_stop) begin
            w_pend_nxt = '0;
          end else if (sw_start && !w_pop_ok) begin
            if (r_pend == PEND_FULL) begin
              w_ovf = 1'b1;
            end else begin
              w_pend_nxt = r_pend + START_Q_W'(1);
            end
          end else if (!sw_start && w_pop_ok) begin
            w_pend_nxt = r_pend - START_Q_W'(1);
          end
        end
        SCH_STR: begin
          w_pend_nxt = '0;
          if (sw_stop) begin
            w_armed_nxt = 1'b0;
          end else if (sw_start) begin
            w_armed_nxt = 1'b1;
          end
        end
        default: begin
          w_pend_nxt  = '0;
          w_armed_nxt = 1'b0;
        end
      endcase
    end
  end

  // Status set sources, one per irq_sts bit.
  always_comb begin
    w_sts_set           = '0;
    w_sts_set[STS_COMP] = frm_comp_pls;
    w_sts_set[STS_ERR]  = frm_err_pls;
    w_sts_set[STS_OVF]  = w_ovf;
    w_sts_set[STS_WDT]  = w_wdt_hit;
  end

  // Sticky W1C status; a set in the same cycle as its clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sts <= '0;
    end else begin
      r_sts <= (r_sts & ~irq_clr) | w_sts_set;
    end
  end

  // Saturating frame and error counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_frm <= '0;
      r_err <= '0;
    end else begin
      if (frm_comp_pls && !(&r_frm)) begin
        r_frm <= r_frm + CNT_W'(1);
      end
      if (frm_err_pls && !(&r_err)) begin
        r_err <= r_err + CNT_W'(1);
      end
    end
  end

  assign cam_rx_start = ((r_mode == SCH_SNG) && (r_pend != '0)) ||
                        ((r_mode == SCH_STR) && r_armed);
  assign start_pend   = r_pend;
  assign sched_mode   = r_mode;
  assign irq_sts      = r_sts;
  assign irq          = |(r_sts & irq_en);
  assign frm_cnt      = r_frm;
  assign err_cnt      = r_err;

endmodule

// File: tb/tb_drc_start_scheduler.sv
// Directed bench for drc_start_scheduler. Expected values are queued when a
// step is driven and compared after the clock edge that should produce them.
// Watchdog checks follow DRC_SCHED_WDT_EN.
module tb_drc_start_scheduler;
  import drc_pkg::*;

  localparam int QW = 3;
  localparam int CW = 16;
  localparam int WW = 24;

  localparam int S_START = 0;
  localparam int S_PEND  = 1;
  localparam int S_STS   = 2;
  localparam int S_IRQ   = 3;
  localparam int S_MODE  = 4;
  localparam int S_FRM   = 5;
  localparam int S_ERR   = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          cam_rx_en;
  logic [1:0]    cam_rx_mode;
  logic          sw_start;
  logic          sw_stop;
  logic          cam_rx_start;
  logic          cam_rx_start_qed;
  logic [2:0]    cam_rx_state;
  logic          frm_comp_pls;
  logic          frm_err_pls;
  logic [3:0]    irq_en;
  logic [3:0]    irq_clr;
  logic          cnt_clr;
  logic [WW-1:0] wdt_limit;
  logic [3:0]    irq_sts;
  logic          irq;
  logic [QW-1:0] start_pend;
  logic [1:0]    sched_mode;
  logic [CW-1:0] frm_cnt;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  drc_start_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .cam_rx_en        (cam_rx_en),
    .cam_rx_mode      (cam_rx_mode),
    .sw_start         (sw_start),
    .sw_stop          (sw_stop),
    .cam_rx_start     (cam_rx_start),
    .cam_rx_start_qed (cam_rx_start_qed),
    .cam_rx_state     (cam_rx_state),
    .frm_comp_pls     (frm_comp_pls),
    .frm_err_pls      (frm_err_pls),
    .irq_en           (irq_en),
    .irq_clr          (irq_clr),
    .cnt_clr          (cnt_clr),
    .wdt_limit        (wdt_limit),
    .irq_sts          (irq_sts),
    .irq              (irq),
    .start_pend       (start_pend),
    .sched_mode       (sched_mode),
    .frm_cnt          (frm_cnt),
    .err_cnt          (err_cnt)
  );

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] obs(input int sig);
    case (sig)
      S_START: return 32'(cam_rx_start);
      S_PEND:  return 32'(start_pend);
      S_STS:   return 32'(irq_sts);
      S_IRQ:   return 32'(irq);
      S_MODE:  return 32'(sched_mode);
      S_FRM:   return 32'(frm_cnt);
      S_ERR:   return 32'(err_cnt);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sig, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic expect_zero(input string tag);
    expect_v({tag, "_start"}, S_START, 0);
    expect_v({tag, "_pend"},  S_PEND,  0);
    expect_v({tag, "_sts"},   S_STS,   0);
    expect_v({tag, "_irq"},   S_IRQ,   0);
    expect_v({tag, "_mode"},  S_MODE,  0);
    expect_v({tag, "_frm"},   S_FRM,   0);
    expect_v({tag, "_err"},   S_ERR,   0);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sig);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    sw_start         = 1'b0;
    sw_stop          = 1'b0;
    cam_rx_start_qed = 1'b0;
    frm_comp_pls     = 1'b0;
    frm_err_pls      = 1'b0;
    irq_clr          = 4'h0;
    cnt_clr          = 1'b0;
  endtask

  task automatic step();
    tick();
    drain();
    clear_pulses();
  endtask

  initial begin
    rst          = 1'b1;
    cam_rx_en    = 1'b0;
    cam_rx_mode  = 2'd0;
    cam_rx_state = 3'd0;
    irq_en       = 4'h0;
    wdt_limit    = '0;
    clear_pulses();
    tick();
    expect_zero("reset");
    step();

    // Single-shot: fill past depth, overflow flag, masked irq.
    rst         = 1'b0;
    cam_rx_en   = 1'b1;
    cam_rx_mode = 2'd1;
    expect_v("sng_mode", S_MODE, 1);
    expect_v("sng_start_idle", S_START, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      sw_start = 1'b1;
      expect_v($sformatf("fill_pend_%0d", i), S_PEND, (i < 4) ? i + 1 : 4);
      expect_v($sformatf("fill_sts_%0d", i), S_STS, (i >= 4) ? 4 : 0);
      expect_v($sformatf("fill_start_%0d", i), S_START, 1);
      step();
    end
    expect_v("ovf_irq_masked", S_IRQ, 0);
    drain();
    irq_en = 4'b0100;
    #1;
    expect_v("ovf_irq_en", S_IRQ, 1);
    drain();
    irq_en = 4'b1011;
    #1;
    expect_v("ovf_irq_other_en", S_IRQ, 0);
    drain();
    irq_clr = 4'b0100;
    expect_v("ovf_clr", S_STS, 0);
    step();

    // Stop with simultaneous push at full: flush, no overflow.
    sw_stop  = 1'b1;
    sw_start = 1'b1;
    expect_v("stop_flush_pend", S_PEND, 0);
    expect_v("stop_flush_start", S_START, 0);
    expect_v("stop_flush_sts", S_STS, 0);
    step();

    // Push/pop same cycle, then drain by pops.
    sw_start = 1'b1;
    expect_v("push1", S_PEND, 1);
    step();
    sw_start = 1'b1;
    expect_v("push2", S_PEND, 2);
    step();
    sw_start         = 1'b1;
    cam_rx_start_qed = 1'b1;
    expect_v("pushpop", S_PEND, 2);
    step();
    cam_rx_start_qed = 1'b1;
    expect_v("pop1_pend", S_PEND, 1);
    expect_v("pop1_start", S_START, 1);
    step();
    cam_rx_start_qed = 1'b1;
    expect_v("pop2_pend", S_PEND, 0);
    expect_v("pop2_start", S_START, 0);
    step();
    cam_rx_start_qed = 1'b1;
    expect_v("pop_underflow", S_PEND, 0);
    step();

    // Stream mode.
    cam_rx_mode = 2'd2;
    expect_v("str_mode", S_MODE, 2);
    expect_v("str_idle", S_START, 0);
    step();
    sw_start = 1'b1;
    expect_v("str_arm", S_START, 1);
    step();
    sw_start = 1'b1;
    sw_stop  = 1'b1;
    expect_v("str_stop_wins", S_START, 0);
    step();
    sw_start = 1'b1;
    expect_v("str_rearm", S_START, 1);
    expect_v("str_pend0", S_PEND, 0);
    step();
    cam_rx_start_qed = 1'b1;
    expect_v("str_qed_ignored", S_START, 1);
    expect_v("str_qed_pend", S_PEND, 0);
    step();
    cam_rx_mode = 2'd1;
    expect_v("str2sng_mode", S_MODE, 1);
    expect_v("str2sng_start", S_START, 0);
    expect_v("str2sng_pend", S_PEND, 0);
    step();

    // Off: enable dropped, starts ignored.
    cam_rx_en = 1'b0;
    expect_v("off_mode", S_MODE, 0);
    step();
    sw_start = 1'b1;
    expect_v("off_start", S_START, 0);
    expect_v("off_pend", S_PEND, 0);
    step();

    // Status and counters.
    irq_en       = 4'h0;
    frm_comp_pls = 1'b1;
    irq_clr      = 4'b0001;
    expect_v("comp_set_wins", S_STS, 1);
    expect_v("comp_cnt", S_FRM, 1);
    expect_v("comp_irq_masked", S_IRQ, 0);
    step();
    irq_en = 4'b0001;
    #1;
    expect_v("comp_irq", S_IRQ, 1);
    drain();
    irq_clr = 4'b0001;
    expect_v("comp_clr", S_STS, 0);
    expect_v("comp_clr_irq", S_IRQ, 0);
    step();
    frm_err_pls = 1'b1;
    expect_v("err_sts", S_STS, 2);
    expect_v("err_cnt", S_ERR, 1);
    expect_v("err_frm_hold", S_FRM, 1);
    expect_v("err_irq_masked", S_IRQ, 0);
    step();
    cnt_clr      = 1'b1;
    frm_comp_pls = 1'b1;
    expect_v("cntclr_frm", S_FRM, 0);
    expect_v("cntclr_err", S_ERR, 0);
    expect_v("cntclr_sts", S_STS, 3);
    expect_v("cntclr_irq", S_IRQ, 1);
    step();
    irq_clr = 4'hF;
    expect_v("sts_clr_all", S_STS, 0);
    step();

    // Saturation at all-ones.
    frm_comp_pls = 1'b1;
    frm_err_pls  = 1'b1;
    repeat (65535) tick();
    expect_v("sat_frm_reach", S_FRM, 32'hFFFF);
    expect_v("sat_err_reach", S_ERR, 32'hFFFF);
    drain();
    frm_comp_pls = 1'b1;
    frm_err_pls  = 1'b1;
    expect_v("sat_frm_hold", S_FRM, 32'hFFFF);
    expect_v("sat_err_hold", S_ERR, 32'hFFFF);
    step();
    cnt_clr = 1'b1;
    irq_clr = 4'hF;
    expect_v("sat_clr_frm", S_FRM, 0);
    expect_v("sat_clr_sts", S_STS, 0);
    step();

    // Watchdog.
    wdt_limit    = WW'(100);
    cam_rx_state = 3'd3;
`ifdef DRC_SCHED_WDT_EN
    repeat (98) tick();
    expect_v("wdt_pre", S_STS, 0);
    step();
    expect_v("wdt_hit", S_STS, 8);
    step();
    repeat (20) tick();
    irq_clr = 4'b1000;
    expect_v("wdt_clr", S_STS, 0);
    step();
    repeat (20) tick();
    expect_v("wdt_once", S_STS, 0);
    drain();
    cam_rx_state = 3'd2;
    repeat (60) tick();
    cam_rx_state = 3'd3;
    repeat (60) tick();
    expect_v("wdt_change_resets", S_STS, 0);
    drain();
`else
    repeat (120) tick();
    expect_v("wdt_absent", S_STS, 0);
    drain();
`endif
    cam_rx_state = 3'd1;
    wdt_limit    = '0;
    irq_clr      = 4'hF;
    expect_v("pre_rst_sts", S_STS, 0);
    step();

    // Reset mid-operation.
    cam_rx_en   = 1'b1;
    cam_rx_mode = 2'd1;
    expect_v("rst_setup_mode", S_MODE, 1);
    step();
    repeat (3) begin
      sw_start = 1'b1;
      step();
    end
    frm_comp_pls = 1'b1;
    frm_err_pls  = 1'b1;
    expect_v("rst_setup_pend", S_PEND, 3);
    expect_v("rst_setup_sts", S_STS, 3);
    expect_v("rst_setup_start", S_START, 1);
    step();
    irq_en = 4'hF;
    rst    = 1'b1;
    sw_start = 1'b1;
    expect_zero("midrst");
    step();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
